// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with shift-add multiply, restoring divide and valid/ready handshake
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_resultado,
  output logic [WIDTH-1:0] out_hi,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow,
  output logic             div_zero,
  output logic             illegal
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_SLTU = 4'b0011,
                         OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_MULU = 4'b1000, OP_DIVU = 4'b1001,
                         OP_REMU = 4'b1010, OP_NOR = 4'b1100;
  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] opnd_q, acc_q, lo_q, acc_d, lo_d, res_q, hi_q, s_res;
  logic             z_q, c_q, v_q, dz_q, ill_q, s_c, s_v, s_dz, s_ill;
  logic [WIDTH:0]   sum, msum, dsh, ddiff;
  logic             is_sub, is_mul, is_long, last;
  assign is_sub  = alu_control == OP_SUB;
  assign is_mul  = alu_control == OP_MULU;
  assign is_long = is_mul || ((alu_control == OP_DIVU || alu_control == OP_REMU) && b != '0);
  assign sum     = {1'b0, a} + {1'b0, is_sub ? ~b : b} + (WIDTH+1)'(is_sub);
  always_comb begin
    s_res = '0;
    s_c   = 1'b0;
    s_v   = 1'b0;
    s_dz  = 1'b0;
    s_ill = 1'b0;
    case (alu_control)
      OP_AND:  s_res = a & b;
      OP_OR:   s_res = a | b;
      OP_NOR:  s_res = ~(a | b);
      OP_ADD, OP_SUB: begin
        s_res = sum[WIDTH-1:0];
        s_c   = sum[WIDTH];
        s_v   = (a[WIDTH-1] ^ b[WIDTH-1] ^ !is_sub) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  s_res = WIDTH'($signed(a) < $signed(b));
      OP_SLTU: s_res = WIDTH'(a < b);
      // divide ops only finish here when the divisor is zero
      OP_DIVU: begin
        s_res = '1;
        s_dz  = 1'b1;
      end
      OP_REMU: begin
        s_res = a;
        s_dz  = 1'b1;
      end
      OP_MULU: s_res = '0;
      default: s_ill = 1'b1;
    endcase
  end
  // acc/lo form one shift pair: product hi/lo for MULU, remainder/quotient for DIVU/REMU
  assign msum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign dsh   = {acc_q, lo_q[WIDTH-1]};
  assign ddiff = dsh - {1'b0, opnd_q};
  assign acc_d = op_q == OP_MULU ? msum[WIDTH:1] : ddiff[WIDTH] ? dsh[WIDTH-1:0] : ddiff[WIDTH-1:0];
  assign lo_d  = op_q == OP_MULU ? {msum[0], lo_q[WIDTH-1:1]} : {lo_q[WIDTH-2:0], !ddiff[WIDTH]};
  assign last  = cnt_q == CW'(WIDTH - 1);
  assign state_d = state_q == IDLE ? (in_valid ? (is_long ? CALC : DONE) : IDLE) :
                   state_q == CALC ? (last ? DONE : CALC) :
                   state_q == DONE ? (out_ready ? IDLE : DONE) : IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      dz_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && in_valid) begin
        op_q   <= alu_control;
        opnd_q <= is_mul ? a : b;
        acc_q  <= '0;
        lo_q   <= is_mul ? b : a;
        cnt_q  <= '0;
        if (!is_long) begin
          res_q <= s_res;
          hi_q  <= '0;
          z_q   <= s_res == '0;
          c_q   <= s_c;
          v_q   <= s_v;
          dz_q  <= s_dz;
          ill_q <= s_ill;
        end
      end else if (state_q == CALC) begin
        acc_q <= acc_d;
        lo_q  <= lo_d;
        cnt_q <= cnt_q + 1'b1;
        if (last) begin
          res_q <= op_q == OP_REMU ? acc_d : lo_d;
          hi_q  <= op_q == OP_MULU ? acc_d : '0;
          z_q   <= (op_q == OP_REMU ? acc_d : lo_d) == '0;
          c_q   <= 1'b0;
          v_q   <= op_q == OP_MULU && acc_d != '0;
          dz_q  <= 1'b0;
          ill_q <= 1'b0;
        end
      end
    end
  end
  assign in_ready      = state_q == IDLE;
  assign out_valid     = state_q == DONE;
  assign out_resultado = res_q;
  assign out_hi        = hi_q;
  assign zero          = z_q;
  assign carry_out     = c_q;
  assign overflow      = v_q;
  assign div_zero      = dz_q;
  assign illegal       = ill_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq with an arithmetic reference model
module tb_alu_seq;
  localparam logic [3:0] AND_ = 4'b0000, ADD_ = 4'b0010, SLTU_ = 4'b0011, SUB_ = 4'b0110,
                         SLT_ = 4'b0111, MULU_ = 4'b1000, DIVU_ = 4'b1001, REMU_ = 4'b1010;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic [3:0]  alu_control = '0;
  logic        in_ready, out_valid, zero, carry_out, overflow, div_zero, illegal;
  logic [31:0] out_resultado, out_hi;
  typedef struct {
    logic [31:0] res, hi;
    logic        z, c, v, dz, ill;
    int          lat, acc;
  } exp_t;
  exp_t q[$];
  int   n_chk = 0, n_fail = 0, cyc = 0;
  bit   seen = 0, rand_rdy = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .alu_control(alu_control), .out_valid(out_valid), .out_ready(out_ready),
    .out_resultado(out_resultado), .out_hi(out_hi), .zero(zero), .carry_out(carry_out),
    .overflow(overflow), .div_zero(div_zero), .illegal(illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(logic [3:0] op, logic [31:0] x, logic [31:0] y);
    exp_t e;
    longint sx = longint'($signed(x)), sy = longint'($signed(y)), s;
    logic [63:0] p;
    e = '{default: 0};
    e.lat = 1;
    case (op)
      4'b0000: e.res = x & y;
      4'b0001: e.res = x | y;
      4'b1100: e.res = ~(x | y);
      4'b0010: begin
        e.res = x + y;
        e.c = (64'(x) + 64'(y)) > 64'hFFFF_FFFF;
        s = sx + sy;
        e.v = s != longint'($signed(s[31:0]));
      end
      4'b0110: begin
        e.res = x - y;
        e.c = x >= y;
        s = sx - sy;
        e.v = s != longint'($signed(s[31:0]));
      end
      4'b0111: e.res = {31'b0, sx < sy};
      4'b0011: e.res = {31'b0, x < y};
      4'b1000: begin
        p = 64'(x) * 64'(y);
        e.res = p[31:0];
        e.hi = p[63:32];
        e.v = e.hi != 0;
        e.lat = 33;
      end
      4'b1001: if (y == 0) begin e.res = '1; e.dz = 1; end else begin e.res = x / y; e.lat = 33; end
      4'b1010: if (y == 0) begin e.res = x; e.dz = 1; end else begin e.res = x % y; e.lat = 33; end
      default: e.ill = 1;
    endcase
    e.z = e.res == 0;
    return e;
  endfunction

  // monitor: every presented cycle is compared, so values must hold under backpressure
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) chk("spurious_valid", 64'(out_valid), 64'd0);
      else begin
        if (!seen) begin
          chk("latency", 64'(cyc - q[0].acc + 1), 64'(q[0].lat));
          seen = 1;
        end
        chk("result", 64'(out_resultado), 64'(q[0].res));
        chk("hi", 64'(out_hi), 64'(q[0].hi));
        chk("flags_zcvdi", 64'({zero, carry_out, overflow, div_zero, illegal}),
            64'({q[0].z, q[0].c, q[0].v, q[0].dz, q[0].ill}));
        chk("in_ready_busy", 64'(in_ready), 64'd0);
        if (out_ready) begin
          void'(q.pop_front());
          seen = 0;
        end
      end
    end
  end

  always @(posedge clk) if (rand_rdy) begin
    #1 out_ready = 1'($urandom_range(0, 1));
  end

  task automatic issue(logic [3:0] op, logic [31:0] x, logic [31:0] y);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
    in_valid = 1; alu_control = op; a = x; b = y;
    e = model(op, x, y);
    @(posedge clk);
    #1 e.acc = cyc;
    q.push_back(e);
    in_valid = 0; a = $urandom; b = $urandom; alu_control = 4'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  task automatic chk_idle_clear(string nm);
    @(negedge clk);
    chk({nm, "_ready_valid"}, 64'({in_ready, out_valid}), 64'b10);
    chk({nm, "_outputs"}, {out_resultado, out_hi}, 64'd0);
    chk({nm, "_flags"}, 64'({zero, carry_out, overflow, div_zero, illegal}), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk_idle_clear("reset");
    issue(ADD_, 32'h7FFF_FFFF, 32'd1);
    issue(SUB_, 32'd0, 32'd0);
    issue(SLT_, 32'hFFFF_FFFD, 32'd2);
    issue(SLTU_, 32'hFFFF_FFFD, 32'd2);
    issue(4'b0101, 32'h1234, 32'h5678);
    issue(MULU_, 32'h0001_0000, 32'h0001_0000);
    issue(MULU_, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(DIVU_, 32'd100, 32'd7);
    issue(REMU_, 32'd100, 32'd7);
    issue(DIVU_, 32'd5, 32'd0);
    issue(REMU_, 32'd5, 32'd0);
    issue(AND_, 32'hF0F0_1234, 32'h0FF0_FFFF);
    drain();
    // backpressure with operand churn while the result is held
    out_ready = 0;
    issue(ADD_, 32'd10, 32'd20);
    repeat (5) begin
      @(negedge clk);
      a = $urandom; b = $urandom; in_valid = 1'($urandom_range(0, 1)); alu_control = ADD_;
    end
    @(negedge clk);
    in_valid = 0;
    @(posedge clk);
    #1 out_ready = 1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_next", 64'({in_ready, out_valid}), 64'b10);
    chk("bp_persist", 64'(out_resultado), 64'd30);
    // reset during MULU, second reset cycle collides with a request
    issue(MULU_, $urandom, $urandom);
    repeat (9) @(posedge clk);
    #1 rst = 1;
    q.delete();
    seen = 0;
    @(posedge clk);
    #1 in_valid = 1; alu_control = ADD_; a = 32'd1; b = 32'd2;
    @(posedge clk);
    #1 rst = 0; in_valid = 0;
    chk_idle_clear("mid_reset");
    issue(ADD_, 32'd10, 32'd20);
    drain();
    rand_rdy = 1;
    for (int i = 0; i < 150; i++) begin
      logic [31:0] x, y;
      x = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 20)) : $urandom;
      y = $urandom_range(0, 4) == 0 ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 3) == 0) y = y >> $urandom_range(0, 31);
      issue(4'($urandom_range(0, 15)), x, y);
    end
    rand_rdy = 0;
    @(posedge clk);
    #1 out_ready = 1;
    drain();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
